// File: rtl/px_block_gather_if.sv
// AXI4-Stream style handshake bundle used by the block gather.
// Sideband: tuser marks start of frame, tlast marks end of line/row.
interface axi4_stream_if #(
  parameter int DW = 8
) ();
  logic [DW-1:0] tdata;
  logic          tvalid;
  logic          tready;
  logic          tuser;
  logic          tlast;

  modport master (
    output tdata, tvalid, tuser, tlast,
    input  tready
  );

  modport slave (
    input  tdata, tvalid, tuser, tlast,
    output tready
  );
endinterface

// File: rtl/px_block_gather.sv
// Gathers NxN pixel blocks from N line streams, one block row per beat.
// A row assembles while the previous row waits in the output register.
module px_block_gather #(
  parameter int PX_WIDTH       = 8,
  parameter int BLOCK_SIZE     = 8,
  parameter int OUT_WIDTH      = PX_WIDTH + 1,
  parameter bit LEVEL_SHIFT_EN = 1'b1,
  parameter int BLK_CNT_WIDTH  = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  axi4_stream_if.slave             ser_video_i [0:BLOCK_SIZE-1],
  axi4_stream_if.master            par_video_o,
  output logic                     err_o,
  output logic [BLK_CNT_WIDTH-1:0] blk_cnt_o
);
  localparam int CW = $clog2(BLOCK_SIZE);
  localparam int RW = BLOCK_SIZE * OUT_WIDTH;
  localparam int AW = RW - OUT_WIDTH;
  localparam logic [CW-1:0] LAST = CW'(BLOCK_SIZE - 1);

  logic [CW-1:0]         px_cnt;
  logic [CW-1:0]         ln_cnt;
  logic [CW-1:0]         ln_tag;
  logic [BLOCK_SIZE-1:0] s_valid;
  logic [BLOCK_SIZE-1:0] s_user;
  logic [BLOCK_SIZE-1:0] s_last;
  logic [PX_WIDTH-1:0]   s_data [BLOCK_SIZE];
  logic [AW-1:0]         asm_q;
  logic [RW-1:0]         out_q;
  logic                  asm_user;
  logic                  out_valid;
  logic                  out_user;
  logic                  out_last;
  logic                  px_last;
  logic                  ln_last;
  logic                  out_hs;
  logic                  sel_ready;
  logic                  acc;
  logic                  cur_user;
  logic                  cur_last;
  logic [PX_WIDTH-1:0]   px;
  logic [OUT_WIDTH-1:0]  elem;
  logic [BLK_CNT_WIDTH-1:0] blk_cnt;

  for (genvar g = 0; g < BLOCK_SIZE; g++) begin : g_ln
    assign s_valid[g] = ser_video_i[g].tvalid;
    assign s_user[g]  = ser_video_i[g].tuser;
    assign s_last[g]  = ser_video_i[g].tlast;
    assign s_data[g]  = ser_video_i[g].tdata[PX_WIDTH-1:0];
    assign ser_video_i[g].tready =
      sel_ready && (ln_cnt == CW'(g));
  end

  assign px_last   = px_cnt == LAST;
  assign ln_last   = ln_cnt == LAST;
  assign out_hs    = out_valid & par_video_o.tready;
  // Only the row-closing pixel depends on the output register.
  assign sel_ready = !px_last | !out_valid
                   | par_video_o.tready;
  assign acc       = s_valid[ln_cnt] & sel_ready;
  assign px        = s_data[ln_cnt];
  assign cur_user  = s_user[ln_cnt];
  assign cur_last  = s_last[ln_cnt];

  always_comb begin
    elem = {{(OUT_WIDTH-PX_WIDTH){1'b0}}, px};
    if (LEVEL_SHIFT_EN)
      elem = elem - (OUT_WIDTH'(1) << (PX_WIDTH-1));
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      px_cnt    <= '0;
      ln_cnt    <= '0;
      ln_tag    <= '0;
      asm_q     <= '0;
      asm_user  <= 1'b0;
      out_q     <= '0;
      out_valid <= 1'b0;
      out_user  <= 1'b0;
      out_last  <= 1'b0;
      err_o     <= 1'b0;
      blk_cnt   <= '0;
    end else begin
      if (out_hs) begin
        out_valid <= 1'b0;
        if (ln_tag == LAST)
          blk_cnt <= blk_cnt + 1'b1;
      end
      if (acc) begin
        px_cnt <= px_last ? '0 : px_cnt + 1'b1;
        if (cur_last && !px_last)
          err_o <= 1'b1;
        if (px_last) begin
          ln_cnt    <= ln_last ? '0 : ln_cnt + 1'b1;
          out_q     <= {elem, asm_q};
          out_user  <= asm_user | cur_user;
          out_last  <= cur_last & ln_last;
          ln_tag    <= ln_cnt;
          out_valid <= 1'b1;
          asm_user  <= 1'b0;
        end else begin
          asm_q[px_cnt*OUT_WIDTH +: OUT_WIDTH] <= elem;
          asm_user <= asm_user | cur_user;
        end
      end
    end
  end

  assign par_video_o.tvalid = out_valid;
  assign par_video_o.tdata  = out_q;
  assign par_video_o.tuser  = out_user;
  assign par_video_o.tlast  = out_last;
  assign blk_cnt_o          = blk_cnt;
endmodule

// File: tb/tb_px_block_gather.sv
// Bench for px_block_gather: row-level model on the 8x8 instance,
// directed literal checks on the unshifted and 4x4/10-bit instances.
module tb_px_block_gather;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst = 1'b1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(string nm, logic [127:0] act,
                     logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic idle(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------- instance A: 8x8, 8-bit, shift on
  typedef struct packed {
    logic [7:0] px;
    logic       user;
    logic       last;
  } beat_t;

  typedef struct {
    logic [71:0] d;
    logic        u;
    logic        l;
    int          tag;
  } row_t;

  beat_t      lq [8][$];
  logic       a_valid [8];
  logic [7:0] a_data [8];
  logic       a_user [8];
  logic       a_last [8];
  logic       a_ready [8];
  logic       pa_ready = 1'b1;
  logic       a_err;
  logic [15:0] a_blk;

  axi4_stream_if #(.DW(8))  sa [0:7] ();
  axi4_stream_if #(.DW(72)) pa ();

  for (genvar g = 0; g < 8; g++) begin : g_a
    assign sa[g].tvalid = a_valid[g];
    assign sa[g].tdata  = a_data[g];
    assign sa[g].tuser  = a_user[g];
    assign sa[g].tlast  = a_last[g];
    assign a_ready[g]   = sa[g].tready;
  end
  assign pa.tready = pa_ready;

  px_block_gather #(
    .PX_WIDTH(8), .BLOCK_SIZE(8), .OUT_WIDTH(9),
    .LEVEL_SHIFT_EN(1'b1), .BLK_CNT_WIDTH(16)
  ) u_a (
    .clk_i(clk), .rst_i(rst),
    .ser_video_i(sa), .par_video_o(pa),
    .err_o(a_err), .blk_cnt_o(a_blk)
  );

  // Model: beats in accept order, rows awaiting handshake.
  beat_t cur [$];
  row_t  exq [$];
  row_t  got [$];
  int    m_row = 0;
  logic  m_err = 1'b0;
  int    m_blk = 0;
  bit    armed = 1'b0;

  function automatic logic [8:0] sh8(logic [7:0] p);
    return 9'(int'(p) - 128);
  endfunction

  always @(negedge clk) if (armed) begin
    bit    hs;
    bit    ac;
    bit    er;
    beat_t b;
    row_t  r;
    row_t  gr;
    chk("a_tvalid", pa.tvalid, exq.size() != 0);
    if (exq.size() != 0) begin
      chk("a_tdata", pa.tdata, exq[0].d);
      chk("a_tuser", pa.tuser, exq[0].u);
      chk("a_tlast", pa.tlast, exq[0].l);
    end
    chk("a_err", a_err, m_err);
    chk("a_blk", a_blk, 16'(m_blk));
    for (int g = 0; g < 8; g++) begin
      er = (g == m_row) && (cur.size() != 7 ||
           exq.size() == 0 || pa_ready);
      chk("a_tready", a_ready[g], er);
    end
    if (rst) begin
      cur.delete();
      exq.delete();
      m_row = 0;
      m_err = 1'b0;
      m_blk = 0;
    end else begin
      hs = exq.size() != 0 && pa_ready;
      ac = a_valid[m_row] && a_ready[m_row];
      if (hs) begin
        gr.d = pa.tdata;
        gr.u = pa.tuser;
        gr.l = pa.tlast;
        gr.tag = 0;
        got.push_back(gr);
        if (exq[0].tag == 7) m_blk++;
        void'(exq.pop_front());
      end
      if (ac) begin
        b = '{px: a_data[m_row], user: a_user[m_row],
              last: a_last[m_row]};
        if (b.last && cur.size() != 7) m_err = 1'b1;
        cur.push_back(b);
        if (cur.size() == 8) begin
          r.d = '0;
          r.u = 1'b0;
          for (int i = 0; i < 8; i++) begin
            r.d[i*9 +: 9] = sh8(cur[i].px);
            r.u = r.u | cur[i].user;
          end
          r.l = cur[7].last && (m_row == 7);
          r.tag = m_row;
          exq.push_back(r);
          cur.delete();
          m_row = (m_row + 1) % 8;
        end
      end
    end
  end

  logic [7:0] sp [3] = '{8'h00, 8'h80, 8'hFF};

  task automatic load_line(int l, bit spec, int tl, bit sof);
    beat_t b;
    for (int p = 0; p < 8; p++) begin
      b.px = (spec && l == 0 && p < 3) ? sp[p]
                                       : 8'(16*l + p);
      b.user = sof && l == 0 && p == 0;
      b.last = (p == 7) || (p == tl);
      lq[l].push_back(b);
    end
  endtask

  task automatic drive();
    for (int g = 0; g < 8; g++) begin
      if (lq[g].size() != 0) begin
        a_valid[g] = 1'b1;
        a_data[g]  = lq[g][0].px;
        a_user[g]  = lq[g][0].user;
        a_last[g]  = lq[g][0].last;
      end else begin
        a_valid[g] = 1'b0;
        a_data[g]  = 8'h00;
        a_user[g]  = 1'b0;
        a_last[g]  = 1'b0;
      end
    end
  endtask

  function automatic bit busy();
    for (int g = 0; g < 8; g++)
      if (lq[g].size() != 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic pump(int mx, output int cyc);
    bit hs [8];
    cyc = 0;
    drive();
    while (cyc < mx && busy()) begin
      @(negedge clk);
      for (int g = 0; g < 8; g++)
        hs[g] = a_valid[g] && a_ready[g];
      @(posedge clk);
      #1;
      for (int g = 0; g < 8; g++)
        if (hs[g]) void'(lq[g].pop_front());
      drive();
      cyc++;
    end
  endtask

  // ---------------- instance B: 8x8, shift off
  logic       b_valid [8];
  logic [7:0] b_data [8];
  logic       b_ready [8];
  logic       b_err;
  logic [15:0] b_blk;
  logic [7:0] bpx [8] = '{8'h00, 8'h80, 8'hFF, 8'h01,
                          8'h02, 8'h03, 8'h04, 8'h05};

  axi4_stream_if #(.DW(8))  sb [0:7] ();
  axi4_stream_if #(.DW(72)) pb ();

  for (genvar g = 0; g < 8; g++) begin : g_b
    assign sb[g].tvalid = b_valid[g];
    assign sb[g].tdata  = b_data[g];
    assign sb[g].tuser  = 1'b0;
    assign sb[g].tlast  = 1'b0;
    assign b_ready[g]   = sb[g].tready;
  end
  assign pb.tready = 1'b1;

  px_block_gather #(
    .PX_WIDTH(8), .BLOCK_SIZE(8), .OUT_WIDTH(9),
    .LEVEL_SHIFT_EN(1'b0), .BLK_CNT_WIDTH(16)
  ) u_b (
    .clk_i(clk), .rst_i(rst),
    .ser_video_i(sb), .par_video_o(pb),
    .err_o(b_err), .blk_cnt_o(b_blk)
  );

  // ---------------- instance C: 4x4, 10-bit, 12-bit out
  logic        c_valid [4];
  logic [15:0] c_data [4];
  logic        c_ready [4];
  logic        c_err;
  logic [7:0]  c_blk;
  int          c_rows = 0;
  logic [11:0] c_row0 = '0;

  axi4_stream_if #(.DW(16)) sc [0:3] ();
  axi4_stream_if #(.DW(48)) pc ();

  for (genvar g = 0; g < 4; g++) begin : g_c
    assign sc[g].tvalid = c_valid[g];
    assign sc[g].tdata  = c_data[g];
    assign sc[g].tuser  = 1'b0;
    assign sc[g].tlast  = 1'b0;
    assign c_ready[g]   = sc[g].tready;
  end
  assign pc.tready = 1'b1;

  px_block_gather #(
    .PX_WIDTH(10), .BLOCK_SIZE(4), .OUT_WIDTH(12),
    .LEVEL_SHIFT_EN(1'b1), .BLK_CNT_WIDTH(8)
  ) u_c (
    .clk_i(clk), .rst_i(rst),
    .ser_video_i(sc), .par_video_o(pc),
    .err_o(c_err), .blk_cnt_o(c_blk)
  );

  always @(negedge clk)
    if (!rst && pc.tvalid === 1'b1) begin
      if (c_rows == 0) c_row0 = pc.tdata[11:0];
      c_rows++;
    end

  // ---------------- sequence
  initial begin
    int cyc;
    int k;
    int to;
    int nl;
    int nu;
    bit hs;
    for (int g = 0; g < 8; g++) begin
      b_valid[g] = 1'b0;
      b_data[g]  = 8'h00;
    end
    for (int g = 0; g < 4; g++) begin
      c_valid[g] = 1'b0;
      c_data[g]  = 16'h0000;
    end
    drive();
    idle(2);
    rst = 1'b0;
    armed = 1'b1;

    chk("rst_tvalid", pa.tvalid, 1'b0);
    chk("rst_tdata", pa.tdata, 72'h0);
    chk("rst_tuser", pa.tuser, 1'b0);
    chk("rst_tlast", pa.tlast, 1'b0);
    chk("rst_err", a_err, 1'b0);
    chk("rst_blk", a_blk, 16'h0);
    chk("rst_ready0", a_ready[0], 1'b1);

    // unshifted boundary pixels on line 0
    k = 0;
    to = 0;
    while (k < 8 && to < 40) begin
      b_valid[0] = 1'b1;
      b_data[0]  = bpx[k];
      @(negedge clk);
      hs = b_ready[0];
      @(posedge clk);
      #1;
      if (hs) k++;
      to++;
    end
    b_valid[0] = 1'b0;
    chk("b_accepts", k, 8);
    chk("b_tvalid", pb.tvalid, 1'b1);
    chk("b_px00", pb.tdata[8:0], 9'h000);
    chk("b_px80", pb.tdata[17:9], 9'h080);
    chk("b_pxFF", pb.tdata[26:18], 9'h0FF);

    // 4x4 10-bit: upper tdata bits must be ignored
    k = 0;
    to = 0;
    while (k < 16 && to < 80) begin
      nl = k / 4;
      for (int g = 0; g < 4; g++) c_valid[g] = 1'b0;
      c_valid[nl] = 1'b1;
      c_data[nl]  = (k == 0) ? 16'hFFFF
                             : 16'(16'hA800 | k);
      @(negedge clk);
      hs = c_ready[nl];
      @(posedge clk);
      #1;
      if (hs) k++;
      to++;
    end
    for (int g = 0; g < 4; g++) c_valid[g] = 1'b0;
    idle(3);
    chk("c_accepts", k, 16);
    chk("c_rows", c_rows, 4);
    chk("c_px3FF", c_row0, 12'h1FF);
    chk("c_blk", c_blk, 8'd1);
    chk("c_err", c_err, 1'b0);
    chk("b_err", b_err, 1'b0);
    chk("b_blk", b_blk, 16'd0);

    // full block, free-running downstream
    got.delete();
    for (int l = 0; l < 8; l++) load_line(l, 0, -1, 0);
    pump(200, cyc);
    chk("t1_no_bubble", cyc, 64);
    idle(3);
    chk("t1_rows", got.size(), 8);
    chk("t1_r0e0", got[0].d[8:0], 9'h180);
    chk("t1_r7e7", got[7].d[71:63], 9'h1F7);
    nl = 0;
    foreach (got[i]) if (got[i].l) nl++;
    chk("t1_nlast", nl, 1);
    chk("t1_r7last", got[7].l, 1'b1);
    chk("t1_blk", a_blk, 16'd1);

    // downstream stall after row 0
    got.delete();
    pa_ready = 1'b0;
    for (int l = 0; l < 8; l++) load_line(l, 1, -1, 0);
    pump(20, cyc);
    chk("t3_l0_left", lq[0].size(), 0);
    chk("t3_l1_left", lq[1].size(), 1);
    chk("t3_l1_ready", a_ready[1], 1'b0);
    chk("t3_hold_v", pa.tvalid, 1'b1);
    chk("t3_px00", pa.tdata[8:0], 9'h180);
    chk("t3_px80", pa.tdata[17:9], 9'h000);
    chk("t3_pxFF", pa.tdata[26:18], 9'h07F);
    pa_ready = 1'b1;
    pump(1, cyc);
    chk("t3_l1_done", lq[1].size(), 0);
    chk("t3_hs", got.size(), 1);
    chk("t3_r1_v", pa.tvalid, 1'b1);
    chk("t3_r1e0", pa.tdata[8:0], 9'h190);
    pump(4, cyc);

    // reset mid-block after 20 pixels
    rst = 1'b1;
    for (int g = 0; g < 8; g++) lq[g].delete();
    drive();
    idle(1);
    rst = 1'b0;
    chk("t7_tvalid", pa.tvalid, 1'b0);
    chk("t7_tdata", pa.tdata, 72'h0);
    chk("t7_blk", a_blk, 16'h0);
    chk("t7_err", a_err, 1'b0);

    // stream 3 early, SOF on line 0 pixel 0
    got.delete();
    load_line(3, 0, -1, 0);
    pump(5, cyc);
    chk("t4_wait", cyc, 5);
    chk("t4_l3_kept", lq[3].size(), 8);
    chk("t4_l3_rdy", a_ready[3], 1'b0);
    for (int l = 0; l < 8; l++)
      if (l != 3) load_line(l, 0, -1, 1);
    pump(200, cyc);
    idle(3);
    chk("t5_rows", got.size(), 8);
    chk("t5_r0e0", got[0].d[8:0], 9'h180);
    chk("t4_r3e0", got[3].d[8:0], 9'h1B0);
    nu = 0;
    foreach (got[i]) if (got[i].u) nu++;
    chk("t5_nuser", nu, 1);
    chk("t5_r0user", got[0].u, 1'b1);
    chk("t5_blk", a_blk, 16'd1);

    // stray tlast on line 2 pixel 4
    chk("t6_err_pre", a_err, 1'b0);
    for (int l = 0; l < 8; l++)
      load_line(l, 0, (l == 2) ? 4 : -1, 0);
    pump(200, cyc);
    idle(3);
    chk("t6_err", a_err, 1'b1);
    chk("t6_blk", a_blk, 16'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end
endmodule
